// File: rtl/mem_req_arbiter.sv
// -----------------------------------------------------------------------------
// mem_req_arbiter
//
// Two-client arbiter in front of the DDR2 line read/write interface.
// Port A (I-cache) only reads; port B (D-cache) reads or writes.
// One 256-bit line transfer is latched at a time and presented to the
// memory-controller side. Completion comes back to the owning client as a
// one-cycle ack, with the read line held in that client's rdata register.
// Clients that are both eligible in the same cycle are served round-robin.
// A watchdog aborts a transfer that the controller never completes.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   a_req/a_addr        port A read request (level, held until a_ack)
//   a_ack/a_rdata       port A done pulse and read line
//   b_req/b_we/b_addr   port B request, direction, address
//   b_wdata             port B write line
//   b_ack/b_rdata       port B done pulse and read line
//   err                 pulses with ack when the transfer was aborted
//   err_sticky          set on any abort, cleared only by rst
//   data_wren/rden      MC write/read command, held for the whole command
//   data_addr/data_wr   MC latched address and write line
//   mc_wr_rdy           MC write-complete pulse
//   mc_rd_rdy           MC can accept a read command this cycle
//   mc_rd_valid/data_rd MC read data strobe and read line
// -----------------------------------------------------------------------------
module mem_req_arbiter #(
   parameter int ADDR_W  = 31,
   parameter int LINE_W  = 256,
   parameter int TIMEOUT = 1023
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              a_req,
   input  logic [ADDR_W-1:0] a_addr,
   output logic              a_ack,
   output logic [LINE_W-1:0] a_rdata,
   input  logic              b_req,
   input  logic              b_we,
   input  logic [ADDR_W-1:0] b_addr,
   input  logic [LINE_W-1:0] b_wdata,
   output logic              b_ack,
   output logic [LINE_W-1:0] b_rdata,
   output logic              err,
   output logic              err_sticky,
   output logic              data_wren,
   output logic              data_rden,
   output logic [ADDR_W-1:0] data_addr,
   output logic [LINE_W-1:0] data_wr,
   input  logic              mc_wr_rdy,
   input  logic              mc_rd_rdy,
   input  logic              mc_rd_valid,
   input  logic [LINE_W-1:0] data_rd
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);
   // The abort is taken in the cycle whose increment would make the count
   // reach TIMEOUT, so RESP lands on cycle TIMEOUT+1 after the command rose.
   localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(TIMEOUT - 1);

   localparam logic PORT_A = 1'b0;
   localparam logic PORT_B = 1'b1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WR   = 2'd1,
      RD   = 2'd2,
      RESP = 2'd3
   } state_t;

   state_t            state_q,     state_d;
   logic              owner_q,     owner_d;
   logic              lastGrant_q, lastGrant_d;
   logic              we_q,        we_d;
   logic [ADDR_W-1:0] addr_q,      addr_d;
   logic [LINE_W-1:0] wdata_q,     wdata_d;
   logic [CNT_W-1:0]  wdogCnt_q,   wdogCnt_d;
   logic              abort_q,     abort_d;
   logic              errSticky_q, errSticky_d;
   logic [LINE_W-1:0] aRdata_q,    aRdata_d;
   logic [LINE_W-1:0] bRdata_q,    bRdata_d;

   logic aElig;
   logic bElig;
   logic grantValid;
   logic grantB;
   logic wdogHit;

   // A read may only be granted while the controller can take a read
   // command; a write from B never waits on mc_rd_rdy, so a stalled read
   // on A does not block B writes.
   assign aElig      = a_req & mc_rd_rdy;
   assign bElig      = b_req & (b_we | mc_rd_rdy);
   assign grantValid = aElig | bElig;
   assign grantB     = (aElig & bElig) ? (lastGrant_q == PORT_A) : bElig;
   assign wdogHit    = (wdogCnt_q == WDOG_LAST);

   // Next-state and datapath latch logic. Every register holds by default;
   // each state only overrides what it changes.
   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      lastGrant_d = lastGrant_q;
      we_d        = we_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      wdogCnt_d   = wdogCnt_q;
      abort_d     = abort_q;
      errSticky_d = errSticky_q;
      aRdata_d    = aRdata_q;
      bRdata_d    = bRdata_q;

      case (state_q)
         IDLE: begin
            if (grantValid) begin
               owner_d     = grantB;
               lastGrant_d = grantB;
               we_d        = grantB & b_we;
               addr_d      = grantB ? b_addr : a_addr;
               if (grantB) begin
                  wdata_d = b_wdata;
               end
               wdogCnt_d = '0;
               abort_d   = 1'b0;
               state_d   = (grantB & b_we) ? WR : RD;
            end
         end

         WR: begin
            // Completion is checked before the watchdog so that a late
            // completion in the abort cycle still counts as success.
            if (mc_wr_rdy) begin
               state_d = RESP;
            end else if (wdogHit) begin
               abort_d     = 1'b1;
               errSticky_d = 1'b1;
               state_d     = RESP;
            end else begin
               wdogCnt_d = wdogCnt_q + CNT_W'(1);
            end
         end

         RD: begin
            if (mc_rd_valid) begin
               if (owner_q == PORT_B) begin
                  bRdata_d = data_rd;
               end else begin
                  aRdata_d = data_rd;
               end
               state_d = RESP;
            end else if (wdogHit) begin
               abort_d     = 1'b1;
               errSticky_d = 1'b1;
               state_d     = RESP;
            end else begin
               wdogCnt_d = wdogCnt_q + CNT_W'(1);
            end
         end

         RESP: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers. Reset drops any command in flight
   // without acknowledging it and re-arms round-robin to favour port A.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         owner_q     <= PORT_A;
         lastGrant_q <= PORT_B;
         we_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         wdogCnt_q   <= '0;
         abort_q     <= 1'b0;
         errSticky_q <= 1'b0;
         aRdata_q    <= '0;
         bRdata_q    <= '0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         lastGrant_q <= lastGrant_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         wdogCnt_q   <= wdogCnt_d;
         abort_q     <= abort_d;
         errSticky_q <= errSticky_d;
         aRdata_q    <= aRdata_d;
         bRdata_q    <= bRdata_d;
      end
   end

   // All outputs decode from registers only, so commands rise the cycle
   // after the grant and RESP forces at least one command-free cycle.
   assign data_wren  = (state_q == WR);
   assign data_rden  = (state_q == RD);
   assign data_addr  = addr_q;
   assign data_wr    = wdata_q;
   assign a_ack      = (state_q == RESP) & (owner_q == PORT_A);
   assign b_ack      = (state_q == RESP) & (owner_q == PORT_B);
   assign err        = (state_q == RESP) & abort_q;
   assign err_sticky = errSticky_q;
   assign a_rdata    = aRdata_q;
   assign b_rdata    = bRdata_q;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_req_arbiter
//
// Directed self-checking bench for mem_req_arbiter, built with TIMEOUT=15.
// Inputs change 1ns after a rising edge and outputs are sampled at the same
// point, so each step() lands in the next clock cycle of the DUT.
// -----------------------------------------------------------------------------
module tb_mem_req_arbiter;

   localparam int ADDR_W  = 31;
   localparam int LINE_W  = 256;
   localparam int TIMEOUT = 15;

   logic              clk;
   logic              rst;
   logic              a_req;
   logic [ADDR_W-1:0] a_addr;
   logic              a_ack;
   logic [LINE_W-1:0] a_rdata;
   logic              b_req;
   logic              b_we;
   logic [ADDR_W-1:0] b_addr;
   logic [LINE_W-1:0] b_wdata;
   logic              b_ack;
   logic [LINE_W-1:0] b_rdata;
   logic              err;
   logic              err_sticky;
   logic              data_wren;
   logic              data_rden;
   logic [ADDR_W-1:0] data_addr;
   logic [LINE_W-1:0] data_wr;
   logic              mc_wr_rdy;
   logic              mc_rd_rdy;
   logic              mc_rd_valid;
   logic [LINE_W-1:0] data_rd;

   int nChecks;
   int nFails;

   mem_req_arbiter #(
      .ADDR_W (ADDR_W),
      .LINE_W (LINE_W),
      .TIMEOUT(TIMEOUT)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .a_req      (a_req),
      .a_addr     (a_addr),
      .a_ack      (a_ack),
      .a_rdata    (a_rdata),
      .b_req      (b_req),
      .b_we       (b_we),
      .b_addr     (b_addr),
      .b_wdata    (b_wdata),
      .b_ack      (b_ack),
      .b_rdata    (b_rdata),
      .err        (err),
      .err_sticky (err_sticky),
      .data_wren  (data_wren),
      .data_rden  (data_rden),
      .data_addr  (data_addr),
      .data_wr    (data_wr),
      .mc_wr_rdy  (mc_wr_rdy),
      .mc_rd_rdy  (mc_rd_rdy),
      .mc_rd_valid(mc_rd_valid),
      .data_rd    (data_rd)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance to the next cycle and settle past the edge.
   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (2) step();
      nChecks++; if ({a_ack, b_ack, err, err_sticky} !== 4'b0000) begin nFails++; $display("[TB] FAIL reset_flags: got %b expected 0000", {a_ack, b_ack, err, err_sticky}); end
      nChecks++; if ({data_wren, data_rden} !== 2'b00) begin nFails++; $display("[TB] FAIL reset_cmds: got %b expected 00", {data_wren, data_rden}); end
      nChecks++; if (data_addr !== '0) begin nFails++; $display("[TB] FAIL reset_addr: got %h expected 0", data_addr); end
      nChecks++; if (data_wr !== '0) begin nFails++; $display("[TB] FAIL reset_wr: got %h expected 0", data_wr); end
      nChecks++; if ((a_rdata | b_rdata) !== '0) begin nFails++; $display("[TB] FAIL reset_rdata: got %h / %h expected 0", a_rdata, b_rdata); end
      rst = 1'b0;
      step();
      nChecks++; if ({data_wren, data_rden, a_ack, b_ack} !== 4'b0000) begin nFails++; $display("[TB] FAIL reset_idle: got %b expected 0000", {data_wren, data_rden, a_ack, b_ack}); end
   endtask

   task automatic test_read_a;
      a_req = 1'b1; a_addr = 31'h100; mc_rd_rdy = 1'b1;
      step();
      nChecks++; if ({data_rden, data_wren} !== 2'b10) begin nFails++; $display("[TB] FAIL rda_cmd: got %b expected 10", {data_rden, data_wren}); end
      nChecks++; if (data_addr !== 31'h100) begin nFails++; $display("[TB] FAIL rda_addr: got %h expected 100", data_addr); end
      mc_rd_rdy = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         nChecks++; if ({data_rden, a_ack} !== 2'b10) begin nFails++; $display("[TB] FAIL rda_wait%0d: got %b expected 10", i, {data_rden, a_ack}); end
      end
      mc_rd_valid = 1'b1; data_rd = {32{8'hAA}};
      step();
      nChecks++; if ({a_ack, b_ack, err, data_rden} !== 4'b1000) begin nFails++; $display("[TB] FAIL rda_ack: got %b expected 1000", {a_ack, b_ack, err, data_rden}); end
      nChecks++; if (a_rdata !== {32{8'hAA}}) begin nFails++; $display("[TB] FAIL rda_rdata: got %h expected aa..", a_rdata); end
      a_req = 1'b0; mc_rd_valid = 1'b0; data_rd = '0;
      step();
      nChecks++; if ({a_ack, data_rden} !== 2'b00) begin nFails++; $display("[TB] FAIL rda_after: got %b expected 00", {a_ack, data_rden}); end
      nChecks++; if (a_rdata !== {32{8'hAA}}) begin nFails++; $display("[TB] FAIL rda_hold: got %h expected aa..", a_rdata); end
   endtask

   task automatic test_write_b;
      b_req = 1'b1; b_we = 1'b1; b_addr = 31'h2A0; b_wdata = {32{8'h55}};
      step();
      nChecks++; if ({data_wren, data_rden} !== 2'b10) begin nFails++; $display("[TB] FAIL wrb_cmd: got %b expected 10", {data_wren, data_rden}); end
      b_addr = 31'h7FF; b_wdata = {32{8'hC3}};
      for (int i = 0; i < 3; i++) begin
         step();
         nChecks++; if (data_addr !== 31'h2A0 || data_wr !== {32{8'h55}} || data_wren !== 1'b1) begin nFails++; $display("[TB] FAIL wrb_stable%0d: got %h %h %b expected 2a0 55.. 1", i, data_addr, data_wr, data_wren); end
      end
      mc_wr_rdy = 1'b1;
      step();
      nChecks++; if ({b_ack, a_ack, err, data_wren} !== 4'b1000) begin nFails++; $display("[TB] FAIL wrb_ack: got %b expected 1000", {b_ack, a_ack, err, data_wren}); end
      mc_wr_rdy = 1'b0; b_req = 1'b0; b_we = 1'b0;
      step();
      nChecks++; if ({b_ack, data_wren, data_rden} !== 3'b000) begin nFails++; $display("[TB] FAIL wrb_after: got %b expected 000", {b_ack, data_wren, data_rden}); end
   endtask

   task automatic test_round_robin;
      logic expA;
      a_req = 1'b1; a_addr = 31'h40; b_req = 1'b1; b_we = 1'b1; b_addr = 31'h80;
      mc_rd_rdy = 1'b1; mc_wr_rdy = 1'b1; mc_rd_valid = 1'b1; data_rd = {32{8'h5A}};
      for (int i = 0; i < 4; i++) begin
         expA = (i % 2 == 0);
         step();
         nChecks++; if ({data_rden, data_wren} !== {expA, ~expA}) begin nFails++; $display("[TB] FAIL rr_cmd%0d: got %b expected %b", i, {data_rden, data_wren}, {expA, ~expA}); end
         step();
         nChecks++; if ({a_ack, b_ack} !== {expA, ~expA}) begin nFails++; $display("[TB] FAIL rr_ack%0d: got %b expected %b", i, {a_ack, b_ack}, {expA, ~expA}); end
         step();
         nChecks++; if ({data_rden, data_wren, a_ack, b_ack} !== 4'b0000) begin nFails++; $display("[TB] FAIL rr_gap%0d: got %b expected 0000", i, {data_rden, data_wren, a_ack, b_ack}); end
      end
      a_req = 1'b0; b_req = 1'b0; b_we = 1'b0;
      mc_rd_rdy = 1'b0; mc_wr_rdy = 1'b0; mc_rd_valid = 1'b0;
      step();
      nChecks++; if (a_rdata !== {32{8'h5A}}) begin nFails++; $display("[TB] FAIL rr_rdata: got %h expected 5a..", a_rdata); end
   endtask

   task automatic test_rd_blocked;
      a_req = 1'b1; a_addr = 31'h140; mc_rd_rdy = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step();
         nChecks++; if ({data_rden, data_wren} !== 2'b00) begin nFails++; $display("[TB] FAIL blk_wait%0d: got %b expected 00", i, {data_rden, data_wren}); end
      end
      b_req = 1'b1; b_we = 1'b1; b_addr = 31'h300; b_wdata = {32{8'h11}};
      step();
      nChecks++; if ({data_wren, data_rden, data_addr} !== {2'b10, 31'h300}) begin nFails++; $display("[TB] FAIL blk_bgrant: got %b %h expected 10 300", {data_wren, data_rden}, data_addr); end
      mc_wr_rdy = 1'b1;
      step();
      nChecks++; if ({b_ack, a_ack} !== 2'b10) begin nFails++; $display("[TB] FAIL blk_back: got %b expected 10", {b_ack, a_ack}); end
      mc_wr_rdy = 1'b0; b_req = 1'b0; b_we = 1'b0;
      repeat (2) step();
      nChecks++; if (data_rden !== 1'b0) begin nFails++; $display("[TB] FAIL blk_still: got %b expected 0", data_rden); end
      mc_rd_rdy = 1'b1;
      step();
      nChecks++; if ({data_rden, data_addr} !== {1'b1, 31'h140}) begin nFails++; $display("[TB] FAIL blk_agrant: got %b %h expected 1 140", data_rden, data_addr); end
      mc_rd_rdy = 1'b0; mc_rd_valid = 1'b1; data_rd = {32{8'h33}};
      step();
      nChecks++; if ({a_ack, a_rdata} !== {1'b1, {32{8'h33}}}) begin nFails++; $display("[TB] FAIL blk_aack: got %b %h expected 1 33..", a_ack, a_rdata); end
      a_req = 1'b0; mc_rd_valid = 1'b0;
      step();
   endtask

   task automatic test_timeout;
      a_req = 1'b1; a_addr = 31'h1F0; mc_rd_rdy = 1'b1;
      step();
      mc_rd_rdy = 1'b0;
      for (int i = 2; i <= 15; i++) begin
         nChecks++; if ({data_rden, a_ack, err} !== 3'b100) begin nFails++; $display("[TB] FAIL to_wait%0d: got %b expected 100", i - 1, {data_rden, a_ack, err}); end
         step();
      end
      nChecks++; if ({data_rden, a_ack, err} !== 3'b100) begin nFails++; $display("[TB] FAIL to_c15: got %b expected 100", {data_rden, a_ack, err}); end
      step();
      nChecks++; if ({a_ack, err, err_sticky, data_rden} !== 4'b1110) begin nFails++; $display("[TB] FAIL to_abort: got %b expected 1110", {a_ack, err, err_sticky, data_rden}); end
      nChecks++; if (a_rdata !== {32{8'h33}}) begin nFails++; $display("[TB] FAIL to_rdata: got %h expected 33..", a_rdata); end
      a_req = 1'b0; mc_rd_valid = 1'b1; data_rd = {32{8'hEE}};
      step();
      nChecks++; if ({a_ack, err, err_sticky} !== 3'b001) begin nFails++; $display("[TB] FAIL to_after: got %b expected 001", {a_ack, err, err_sticky}); end
      nChecks++; if (a_rdata !== {32{8'h33}}) begin nFails++; $display("[TB] FAIL to_ignore: got %h expected 33..", a_rdata); end
      mc_rd_valid = 1'b0;
   endtask

   task automatic test_timeout_tie;
      b_req = 1'b1; b_we = 1'b0; b_addr = 31'h3C0; mc_rd_rdy = 1'b1;
      step();
      mc_rd_rdy = 1'b0;
      repeat (14) step();
      nChecks++; if ({data_rden, b_ack} !== 2'b10) begin nFails++; $display("[TB] FAIL tie_c15: got %b expected 10", {data_rden, b_ack}); end
      mc_rd_valid = 1'b1; data_rd = {32{8'h77}};
      step();
      nChecks++; if ({b_ack, a_ack, err, err_sticky} !== 4'b1001) begin nFails++; $display("[TB] FAIL tie_ack: got %b expected 1001", {b_ack, a_ack, err, err_sticky}); end
      nChecks++; if (b_rdata !== {32{8'h77}}) begin nFails++; $display("[TB] FAIL tie_rdata: got %h expected 77..", b_rdata); end
      b_req = 1'b0; mc_rd_valid = 1'b0;
      step();
   endtask

   task automatic test_reset_mid;
      a_req = 1'b1; a_addr = 31'h080; mc_rd_rdy = 1'b1;
      step();
      nChecks++; if (data_rden !== 1'b1) begin nFails++; $display("[TB] FAIL rm_cmd: got %b expected 1", data_rden); end
      rst = 1'b1; a_req = 1'b0;
      step();
      nChecks++; if ({data_rden, a_ack, err_sticky} !== 3'b000) begin nFails++; $display("[TB] FAIL rm_drop: got %b expected 000", {data_rden, a_ack, err_sticky}); end
      rst = 1'b0;
      step();
      nChecks++; if ({data_rden, a_ack} !== 2'b00) begin nFails++; $display("[TB] FAIL rm_noack: got %b expected 00", {data_rden, a_ack}); end
      a_req = 1'b1; a_addr = 31'h0C0;
      step();
      nChecks++; if ({data_rden, data_addr} !== {1'b1, 31'h0C0}) begin nFails++; $display("[TB] FAIL rm_regrant: got %b %h expected 1 0c0", data_rden, data_addr); end
      mc_rd_rdy = 1'b0; mc_rd_valid = 1'b1; data_rd = {32{8'h99}};
      step();
      nChecks++; if ({a_ack, err, a_rdata} !== {2'b10, {32{8'h99}}}) begin nFails++; $display("[TB] FAIL rm_done: got %b %h expected 10 99..", {a_ack, err}, a_rdata); end
      a_req = 1'b0; mc_rd_valid = 1'b0;
      step();
   endtask

   initial begin
      nChecks = 0; nFails = 0;
      rst = 1'b1;
      a_req = 1'b0; a_addr = '0;
      b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
      mc_wr_rdy = 1'b0; mc_rd_rdy = 1'b0; mc_rd_valid = 1'b0; data_rd = '0;
      test_reset();
      test_read_a();
      test_write_b();
      test_round_robin();
      test_rd_blocked();
      test_timeout();
      test_timeout_tie();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
